// File: rtl/instr_decoder.sv
// Registered decoder splitting the instruction register into ALU, bus
// and control-unit bundles; conditional jumps are resolved from zf/cf.
module instr_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] ir,
    input  logic        zf,
    input  logic        cf,
    output logic [2:0]  alu_op,
    output logic        alu_a_sel,
    output logic [3:0]  alu_s_reg,
    output logic [3:0]  alu_b_reg,
    output logic [3:0]  alu_a_reg,
    output logic [63:0] alu_a_imm,
    output logic [1:0]  bus_op,
    output logic        bus_data_type,
    output logic [3:0]  bus_data_reg,
    output logic [3:0]  bus_addr_reg,
    output logic [16:0] bus_addr_offset,
    output logic [2:0]  cu_op,
    output logic [7:0]  cu_exit_code_imm,
    output logic [25:0] cu_jmp_offset,
    output logic [3:0]  cu_reg0,
    output logic [3:0]  cu_reg1
);

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MULW = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_SHR  = 3'd5;
    localparam logic [2:0] ALU_SHL  = 3'd6;

    localparam logic [1:0] BUS_NOP   = 2'd0;
    localparam logic [1:0] BUS_FETCH = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [2:0] CU_NOP      = 3'd0;
    localparam logic [2:0] CU_HALT_IMM = 3'd1;
    localparam logic [2:0] CU_HALT_REG = 3'd2;
    localparam logic [2:0] CU_REL_JMP  = 3'd3;
    localparam logic [2:0] CU_ABS_JMP  = 3'd4;

    localparam logic SEL_REG = 1'b0;
    localparam logic SEL_IMM = 1'b1;
    localparam logic BYTE    = 1'b0;
    localparam logic QUAD    = 1'b1;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic        alu_a_sel;
        logic [3:0]  alu_s;
        logic [3:0]  alu_b;
        logic [3:0]  alu_a;
        logic [63:0] alu_imm;
        logic [1:0]  bus_op;
        logic        bus_type;
        logic [3:0]  bus_data;
        logic [3:0]  bus_addr;
        logic [16:0] bus_off;
        logic [2:0]  cu_op;
        logic [7:0]  cu_exit;
        logic [25:0] cu_jmp;
        logic [3:0]  cu_reg0;
        logic [3:0]  cu_reg1;
    } dec_t;

    dec_t       dec_d;
    dec_t       dec_q;
    logic [7:0] opc;

    assign opc = ir[31:24];

    always_comb begin
        dec_d           = '0;
        dec_d.alu_op    = ALU_NOP;
        dec_d.alu_a_sel = SEL_REG;
        dec_d.alu_s     = ir[23:20];
        dec_d.alu_b     = ir[19:16];
        dec_d.alu_a     = ir[15:12];
        dec_d.alu_imm   = {48'd0, ir[15:0]};
        dec_d.bus_op    = BUS_NOP;
        dec_d.bus_type  = BYTE;
        dec_d.bus_data  = ir[23:20];
        dec_d.bus_addr  = ir[19:16];
        dec_d.bus_off   = {ir[15], ir[15:0]};
        dec_d.cu_op     = CU_NOP;
        dec_d.cu_exit   = ir[23:16];
        dec_d.cu_jmp    = {ir[23:0], 2'b00};
        dec_d.cu_reg0   = ir[23:20];
        dec_d.cu_reg1   = ir[19:16];

        case (opc)
            8'h10: begin
                // ldzwq: load a 20-bit immediate via ADD with zeroed sources
                dec_d.alu_op    = ALU_ADD;
                dec_d.alu_a_sel = SEL_IMM;
                dec_d.alu_b     = 4'd0;
                dec_d.alu_a     = 4'd0;
                dec_d.alu_imm   = {44'd0, ir[19:0]};
            end
            8'h11: dec_d.alu_op = ALU_ADD;
            8'h12: begin
                dec_d.alu_op    = ALU_ADD;
                dec_d.alu_a_sel = SEL_IMM;
            end
            8'h13: dec_d.alu_op = ALU_SUB;
            8'h14: begin
                dec_d.alu_op    = ALU_SUB;
                dec_d.alu_a_sel = SEL_IMM;
            end
            8'h15: dec_d.alu_op = ALU_MULW;
            8'h16: dec_d.alu_op = ALU_AND;
            8'h17: begin
                dec_d.alu_op    = ALU_SHR;
                dec_d.alu_a_sel = SEL_IMM;
            end
            8'h18: begin
                dec_d.alu_op    = ALU_SHL;
                dec_d.alu_a_sel = SEL_IMM;
            end
            default: ;
        endcase

        case (opc)
            8'h20: dec_d.bus_op = BUS_FETCH;
            8'h22: dec_d.bus_op = BUS_STORE;
            8'h23: begin
                dec_d.bus_op   = BUS_FETCH;
                dec_d.bus_type = QUAD;
            end
            8'h24: begin
                dec_d.bus_op   = BUS_STORE;
                dec_d.bus_type = QUAD;
            end
            default: ;
        endcase

        case (opc)
            8'h01: dec_d.cu_op = CU_HALT_IMM;
            8'h02: dec_d.cu_op = CU_HALT_REG;
            8'h03: dec_d.cu_op = !zf ? CU_REL_JMP : CU_NOP;
            8'h04: dec_d.cu_op = zf ? CU_REL_JMP : CU_NOP;
            8'h05: dec_d.cu_op = CU_REL_JMP;
            8'h06: dec_d.cu_op = cf ? CU_REL_JMP : CU_NOP;
            8'h07: dec_d.cu_op = CU_ABS_JMP;
            8'h08: dec_d.cu_op = (zf | cf) ? CU_REL_JMP : CU_NOP;
            8'h09: dec_d.cu_op = (!zf & !cf) ? CU_REL_JMP : CU_NOP;
            8'h0A: dec_d.cu_op = !cf ? CU_REL_JMP : CU_NOP;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else if (en) begin
            dec_q <= dec_d;
        end
    end

    assign alu_op           = dec_q.alu_op;
    assign alu_a_sel        = dec_q.alu_a_sel;
    assign alu_s_reg        = dec_q.alu_s;
    assign alu_b_reg        = dec_q.alu_b;
    assign alu_a_reg        = dec_q.alu_a;
    assign alu_a_imm        = dec_q.alu_imm;
    assign bus_op           = dec_q.bus_op;
    assign bus_data_type    = dec_q.bus_type;
    assign bus_data_reg     = dec_q.bus_data;
    assign bus_addr_reg     = dec_q.bus_addr;
    assign bus_addr_offset  = dec_q.bus_off;
    assign cu_op            = dec_q.cu_op;
    assign cu_exit_code_imm = dec_q.cu_exit;
    assign cu_jmp_offset    = dec_q.cu_jmp;
    assign cu_reg0          = dec_q.cu_reg0;
    assign cu_reg1          = dec_q.cu_reg1;

endmodule

// File: tb/tb_instr_decoder.sv
// Randomized bench for instr_decoder against a table-driven opcode model.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] ir;
    logic        zf;
    logic        cf;
    logic [2:0]  alu_op;
    logic        alu_a_sel;
    logic [3:0]  alu_s_reg;
    logic [3:0]  alu_b_reg;
    logic [3:0]  alu_a_reg;
    logic [63:0] alu_a_imm;
    logic [1:0]  bus_op;
    logic        bus_data_type;
    logic [3:0]  bus_data_reg;
    logic [3:0]  bus_addr_reg;
    logic [16:0] bus_addr_offset;
    logic [2:0]  cu_op;
    logic [7:0]  cu_exit_code_imm;
    logic [25:0] cu_jmp_offset;
    logic [3:0]  cu_reg0;
    logic [3:0]  cu_reg1;

    instr_decoder dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .ir               (ir),
        .zf               (zf),
        .cf               (cf),
        .alu_op           (alu_op),
        .alu_a_sel        (alu_a_sel),
        .alu_s_reg        (alu_s_reg),
        .alu_b_reg        (alu_b_reg),
        .alu_a_reg        (alu_a_reg),
        .alu_a_imm        (alu_a_imm),
        .bus_op           (bus_op),
        .bus_data_type    (bus_data_type),
        .bus_data_reg     (bus_data_reg),
        .bus_addr_reg     (bus_addr_reg),
        .bus_addr_offset  (bus_addr_offset),
        .cu_op            (cu_op),
        .cu_exit_code_imm (cu_exit_code_imm),
        .cu_jmp_offset    (cu_jmp_offset),
        .cu_reg0          (cu_reg0),
        .cu_reg1          (cu_reg1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Per-opcode tables; cond_tab bit index is {zf,cf}
    logic [2:0] alu_tab  [256];
    logic       imm_tab  [256];
    logic [1:0] bus_tab  [256];
    logic       quad_tab [256];
    logic [2:0] cu_tab   [256];
    logic [3:0] cond_tab [256];

    logic [2:0]  m_alu_op;
    logic        m_sel;
    logic [3:0]  m_s, m_b, m_a;
    logic [63:0] m_imm;
    logic [1:0]  m_bus_op;
    logic        m_quad;
    logic [3:0]  m_data, m_addr;
    logic [16:0] m_off;
    logic [2:0]  m_cu_op;
    logic [7:0]  m_exit;
    logic [25:0] m_jmp;
    logic [3:0]  m_r0, m_r1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (ir=%h)", tag, got, exp, ir);
        end
    endtask

    task automatic init_tables();
        for (int i = 0; i < 256; i++) begin
            alu_tab[i] = 3'd0; imm_tab[i] = 1'b0;
            bus_tab[i] = 2'd0; quad_tab[i] = 1'b0;
            cu_tab[i] = 3'd0;  cond_tab[i] = 4'b1111;
        end
        alu_tab[8'h10] = 3'd1; imm_tab[8'h10] = 1'b1;
        alu_tab[8'h11] = 3'd1;
        alu_tab[8'h12] = 3'd1; imm_tab[8'h12] = 1'b1;
        alu_tab[8'h13] = 3'd2;
        alu_tab[8'h14] = 3'd2; imm_tab[8'h14] = 1'b1;
        alu_tab[8'h15] = 3'd3;
        alu_tab[8'h16] = 3'd4;
        alu_tab[8'h17] = 3'd5; imm_tab[8'h17] = 1'b1;
        alu_tab[8'h18] = 3'd6; imm_tab[8'h18] = 1'b1;
        bus_tab[8'h20] = 2'd1;
        bus_tab[8'h22] = 2'd2;
        bus_tab[8'h23] = 2'd1; quad_tab[8'h23] = 1'b1;
        bus_tab[8'h24] = 2'd2; quad_tab[8'h24] = 1'b1;
        cu_tab[8'h01] = 3'd1;
        cu_tab[8'h02] = 3'd2;
        cu_tab[8'h05] = 3'd3;
        cu_tab[8'h07] = 3'd4;
        for (int i = 3; i <= 10; i++)
            if (i != 5 && i != 7) cu_tab[i] = 3'd3;
        cond_tab[8'h03] = 4'b0011;
        cond_tab[8'h04] = 4'b1100;
        cond_tab[8'h06] = 4'b1010;
        cond_tab[8'h08] = 4'b1110;
        cond_tab[8'h09] = 4'b0001;
        cond_tab[8'h0A] = 4'b0101;
    endtask

    task automatic model_clear();
        m_alu_op = 0; m_sel = 0; m_s = 0; m_b = 0; m_a = 0; m_imm = 0;
        m_bus_op = 0; m_quad = 0; m_data = 0; m_addr = 0; m_off = 0;
        m_cu_op = 0; m_exit = 0; m_jmp = 0; m_r0 = 0; m_r1 = 0;
    endtask

    task automatic model_edge();
        int  o;
        int  v;
        logic [3:0] mask;
        if (rst) begin
            model_clear();
        end else if (en) begin
            o = int'(ir[31:24]);
            m_alu_op = alu_tab[o];
            m_sel    = imm_tab[o];
            m_s      = ir[23:20];
            m_b      = (o == 16) ? 4'd0 : ir[19:16];
            m_a      = (o == 16) ? 4'd0 : ir[15:12];
            m_imm    = (o == 16) ? 64'(ir[19:0]) : 64'(ir[15:0]);
            m_bus_op = bus_tab[o];
            m_quad   = quad_tab[o];
            m_data   = ir[23:20];
            m_addr   = ir[19:16];
            v = int'(ir[15:0]);
            if (v >= 32768) v = v - 65536;
            m_off    = v[16:0];
            mask     = cond_tab[o];
            m_cu_op  = mask[{zf, cf}] ? cu_tab[o] : 3'd0;
            m_exit   = ir[23:16];
            m_jmp    = 26'(ir[23:0] * 4);
            m_r0     = ir[23:20];
            m_r1     = ir[19:16];
        end
    endtask

    task automatic compare_all();
        check("alu_op",    64'(alu_op),           64'(m_alu_op));
        check("alu_a_sel", 64'(alu_a_sel),        64'(m_sel));
        check("alu_s",     64'(alu_s_reg),        64'(m_s));
        check("alu_b",     64'(alu_b_reg),        64'(m_b));
        check("alu_a",     64'(alu_a_reg),        64'(m_a));
        check("alu_imm",   alu_a_imm,             m_imm);
        check("bus_op",    64'(bus_op),           64'(m_bus_op));
        check("bus_type",  64'(bus_data_type),    64'(m_quad));
        check("bus_data",  64'(bus_data_reg),     64'(m_data));
        check("bus_addr",  64'(bus_addr_reg),     64'(m_addr));
        check("bus_off",   64'(bus_addr_offset),  64'(m_off));
        check("cu_op",     64'(cu_op),            64'(m_cu_op));
        check("cu_exit",   64'(cu_exit_code_imm), 64'(m_exit));
        check("cu_jmp",    64'(cu_jmp_offset),    64'(m_jmp));
        check("cu_reg0",   64'(cu_reg0),          64'(m_r0));
        check("cu_reg1",   64'(cu_reg1),          64'(m_r1));
    endtask

    task automatic step(input logic r, input logic e, input logic [31:0] w,
                        input logic z, input logic c);
        rst = r; en = e; ir = w; zf = z; cf = c;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] o;
        logic [31:0] w;
        init_tables();
        model_clear();
        rst = 1'b1; en = 1'b1; ir = 32'h11123000; zf = 1'b0; cf = 1'b0;

        step(1, 1, 32'h11123000, 0, 0);
        check("rst_all_zero", 64'({alu_op, alu_s_reg, cu_op, bus_op}), 64'd0);
        step(1, 1, 32'h11123000, 1, 1);

        step(0, 1, 32'h10ABCDEF, 0, 0);
        check("ldzwq_imm", alu_a_imm, 64'hBCDEF);
        step(0, 1, 32'h14345678, 0, 0);
        check("subi_op", 64'(alu_op), 64'd2);
        step(0, 1, 32'h2312FFF0, 0, 0);
        check("fetchq_off", 64'(bus_addr_offset), 64'h1FFF0);
        step(0, 1, 32'h22340010, 0, 0);
        step(0, 1, 32'h21000000, 0, 0);
        step(0, 1, 32'h04000003, 1, 0);
        check("jz_taken", 64'(cu_op), 64'd3);
        check("jz_off", 64'(cu_jmp_offset), 64'hC);
        step(0, 1, 32'h04000003, 0, 0);
        check("jz_not", 64'(cu_op), 64'd0);
        step(0, 1, 32'h09000001, 0, 1);

        step(0, 1, 32'h01070000, 0, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, $urandom(), 1'($urandom()), 1'($urandom()));
        check("hold_exit", 64'(cu_exit_code_imm), 64'd7);
        check("hold_op", 64'(cu_op), 64'd1);

        step(0, 1, 32'h07560000, 0, 0);
        step(0, 1, 32'h02900000, 0, 0);
        step(0, 1, 32'hFF000000, 1, 1);
        // Reset must win over en
        step(1, 1, 32'h05FFFFFF, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0)
                o = 8'($urandom_range(0, 8'h2F));
            else
                o = 8'($urandom());
            w = {o, 24'($urandom())};
            step(1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 3) != 0),
                 w, 1'($urandom()), 1'($urandom()));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
